// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard scoreboard.
// Slot records carry the producer fields of one in-flight instruction.
package fwd_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_RF     = 0;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  memread;
    logic [REG_ADDR_W-1:0] rd;
  } slot_t;

  // r0 is hard-wired, so a write to it never produces a forwardable value.
  function automatic logic isLive(input slot_t s);
    return s.valid && s.regwrite && (s.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Nearest-slot priority comparator: returns the lowest slot index whose
// candidate bit is set and whose rd equals src, or FWD_RF when none does.
module fwd_match #(
  parameter int REG_ADDR_W = fwd_pkg::REG_ADDR_W,
  parameter int DEPTH      = 3,
  parameter int SEL_W      = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            cand,
  input  logic [DEPTH*REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0]       src,
  output logic [SEL_W-1:0]            sel
);
  import fwd_pkg::*;

  always_comb begin
    // NOTE: sel gets a default before the loop so every path assigns it;
    // without it this block would infer a latch.
    sel = SEL_W'(FWD_RF);
    // NOTE: blocking assignments here let a later (lower-index) match
    // overwrite an earlier one, so the scan runs high-to-low and nearest wins.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (cand[k] && (rd[k*REG_ADDR_W +: REG_ADDR_W] == src)) begin
        sel = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Scoreboard-based forwarding and load-use hazard unit. Tracks DEPTH post-ID
// slots, selects the nearest producer per EX operand and stalls ID on load-use.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = fwd_pkg::REG_ADDR_W,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_SLOT  = 2,
  parameter int SEL_W      = $clog2(DEPTH),
  parameter int CNT_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          freeze_i,
  input  logic                          flush_i,
  input  logic                          id_valid_i,
  input  logic                          id_regwrite_i,
  input  logic                          id_memread_i,
  input  logic [REG_ADDR_W-1:0]         id_rd_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_i,
  output logic                          stall_o,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o,
  output logic [CNT_W-1:0]              stall_cnt_o,
  output logic [CNT_W-1:0]              fwd_cnt_o
);
  import fwd_pkg::*;

  // Slot records use the package address width; REG_ADDR_W must match it.
  slot_t                       slots [DEPTH];
  logic [REG_ADDR_W-1:0]       exRs  [NUM_SRC];
  logic [DEPTH*REG_ADDR_W-1:0] slotRd;
  logic [DEPTH*REG_ADDR_W-1:0] stallRd;
  logic [DEPTH-1:0]            fwdCand;
  logic [DEPTH-1:0]            stallCand;
  logic [NUM_SRC-1:0]          fwdHit;
  logic [NUM_SRC-1:0]          stallHit;
  logic [CNT_W-1:0]            stallCnt;
  logic [CNT_W-1:0]            fwdCnt;
  logic                        loadId;

  for (genvar k = 0; k < DEPTH; k++) begin : gFlat
    assign slotRd[k*REG_ADDR_W +: REG_ADDR_W] = slots[k].rd;
  end

  // Stall lookups are shifted up one position so that select 0 stays the
  // "no match" code while slot 0 (EX) can still be a stall source.
  assign stallRd = {slotRd[(DEPTH-1)*REG_ADDR_W-1:0], {REG_ADDR_W{1'b0}}};

  always_comb begin
    fwdCand   = '0;
    stallCand = '0;
    for (int k = 1; k < DEPTH; k++) begin
      fwdCand[k] = isLive(slots[k]) && !(slots[k].memread && (k < LOAD_SLOT));
    end
    for (int j = 0; j < DEPTH - 1; j++) begin
      stallCand[j+1] = isLive(slots[j]) && slots[j].memread && (j < LOAD_SLOT - 1);
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
    logic [SEL_W-1:0] fwdSel;
    logic [SEL_W-1:0] stallSel;

    fwd_match #(
      .REG_ADDR_W(REG_ADDR_W),
      .DEPTH     (DEPTH),
      .SEL_W     (SEL_W)
    ) uFwd (
      .cand(fwdCand),
      .rd  (slotRd),
      .src (exRs[i]),
      .sel (fwdSel)
    );

    fwd_match #(
      .REG_ADDR_W(REG_ADDR_W),
      .DEPTH     (DEPTH),
      .SEL_W     (SEL_W)
    ) uStall (
      .cand(stallCand),
      .rd  (stallRd),
      .src (id_rs_i[i*REG_ADDR_W +: REG_ADDR_W]),
      .sel (stallSel)
    );

    assign fwd_sel_o[i*SEL_W +: SEL_W] = fwdSel;
    assign fwdHit[i]   = (fwdSel != SEL_W'(FWD_RF));
    assign stallHit[i] = (stallSel != SEL_W'(FWD_RF));
  end

  assign stall_o = id_valid_i && !flush_i && (|stallHit);
  assign loadId  = id_valid_i && !flush_i && !stall_o;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so the slot shift
    // reads the pre-edge values of every slot.
    if (rst_i) begin
      // NOTE: the slots are a handful of flops, so the whole record is cleared
      // rather than just valid; this keeps X out of the rd comparators.
      for (int k = 0; k < DEPTH; k++) begin
        slots[k] <= '0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        exRs[i] <= '0;
      end
      stallCnt <= '0;
      fwdCnt   <= '0;
    end else if (!freeze_i) begin
      for (int k = 1; k < DEPTH; k++) begin
        slots[k] <= slots[k-1];
      end
      // Bubbles also clear ex_rs; a source of r0 can never match a producer.
      if (loadId) begin
        slots[0] <= '{valid: 1'b1, regwrite: id_regwrite_i,
                      memread: id_memread_i, rd: id_rd_i};
        for (int i = 0; i < NUM_SRC; i++) begin
          exRs[i] <= id_rs_i[i*REG_ADDR_W +: REG_ADDR_W];
        end
      end else begin
        slots[0] <= '0;
        for (int i = 0; i < NUM_SRC; i++) begin
          exRs[i] <= '0;
        end
      end
      if (stall_o && (stallCnt != '1)) begin
        stallCnt <= stallCnt + 1'b1;
      end
      if ((|fwdHit) && (fwdCnt != '1)) begin
        fwdCnt <= fwdCnt + 1'b1;
      end
    end
  end

  assign stall_cnt_o = stallCnt;
  assign fwd_cnt_o   = fwdCnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: hand-computed selects, stalls and
// counters; a second instance with 4-bit counters covers saturation.
module tb_fwd_hazard_unit;

  localparam int W  = 5;
  localparam int NS = 2;
  localparam int D  = 3;
  localparam int SW = 2;

  logic           clk        = 1'b0;
  logic           rst        = 1'b1;
  logic           freeze     = 1'b0;
  logic           flush      = 1'b0;
  logic           idValid    = 1'b0;
  logic           idRegwrite = 1'b0;
  logic           idMemread  = 1'b0;
  logic [W-1:0]   idRd       = '0;
  logic [NS*W-1:0] idRs      = '0;

  logic            stall,  stall4;
  logic [NS*SW-1:0] fwdSel, fwdSel4;
  logic [15:0]     stallCnt, fwdCnt;
  logic [3:0]      stallCnt4, fwdCnt4;

  int nChecks = 0;
  int nBad    = 0;
  int expStall = 0;
  int expFwd   = 0;

  fwd_hazard_unit #(
    .REG_ADDR_W(W), .NUM_SRC(NS), .DEPTH(D), .LOAD_SLOT(2), .SEL_W(SW), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .freeze_i(freeze), .flush_i(flush),
    .id_valid_i(idValid), .id_regwrite_i(idRegwrite), .id_memread_i(idMemread),
    .id_rd_i(idRd), .id_rs_i(idRs),
    .stall_o(stall), .fwd_sel_o(fwdSel), .stall_cnt_o(stallCnt), .fwd_cnt_o(fwdCnt)
  );

  fwd_hazard_unit #(
    .REG_ADDR_W(W), .NUM_SRC(NS), .DEPTH(D), .LOAD_SLOT(2), .SEL_W(SW), .CNT_W(4)
  ) dut4 (
    .clk_i(clk), .rst_i(rst), .freeze_i(freeze), .flush_i(flush),
    .id_valid_i(idValid), .id_regwrite_i(idRegwrite), .id_memread_i(idMemread),
    .id_rd_i(idRd), .id_rs_i(idRs),
    .stall_o(stall4), .fwd_sel_o(fwdSel4), .stall_cnt_o(stallCnt4), .fwd_cnt_o(fwdCnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int v, input int rw, input int mr,
                       input int rd, input int rs0, input int rs1);
    idValid    = 1'(v);
    idRegwrite = 1'(rw);
    idMemread  = 1'(mr);
    idRd       = W'(rd);
    idRs       = {W'(rs1), W'(rs0)};
    #1;
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    repeat (3) begin
      nop();
      tick();
    end
  endtask

  function automatic logic [31:0] sels(input int s0, input int s1);
    return 32'({SW'(s1), SW'(s0)});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    nop();
    check("reset_stall",    32'(stall),    0);
    check("reset_sel",      32'(fwdSel),   0);
    check("reset_stallcnt", 32'(stallCnt), 0);
    check("reset_fwdcnt",   32'(fwdCnt),   0);

    // add r3,r1,r2 ; sub r4,r3,r1
    issue(1, 1, 0, 3, 1, 2); tick();
    issue(1, 1, 0, 4, 3, 1); tick();
    check("alu_pair_sel",   32'(fwdSel), sels(1, 0));
    check("alu_pair_stall", 32'(stall),  0);
    nop(); tick();
    expFwd = 1;
    check("alu_pair_cnt",   32'(fwdCnt), 32'(expFwd));
    drain();

    // add r5 ; nop ; or r6,r2,r5
    issue(1, 1, 0, 5, 1, 1); tick();
    nop(); tick();
    issue(1, 1, 0, 6, 2, 5); tick();
    check("dist2_sel", 32'(fwdSel), sels(0, 2));
    nop(); tick();
    expFwd = 2;
    check("dist2_cnt", 32'(fwdCnt), 32'(expFwd));
    drain();

    // add r5 ; add r5 ; or r6,r2,r5 -> nearest producer
    issue(1, 1, 0, 5, 1, 1); tick();
    issue(1, 1, 0, 5, 1, 1); tick();
    issue(1, 1, 0, 6, 2, 5); tick();
    check("nearest_sel", 32'(fwdSel), sels(0, 1));
    nop(); tick();
    expFwd = 3;
    drain();

    // lw r7 ; add r8,r7,r7
    issue(1, 1, 1, 7, 1, 0); tick();
    issue(1, 1, 0, 8, 7, 7);
    check("lu_stall_on", 32'(stall), 1);
    tick();
    expStall = 1;
    check("lu_stall_once",  32'(stall),    0);
    check("lu_bubble_sel",  32'(fwdSel),   0);
    check("lu_stallcnt",    32'(stallCnt), 32'(expStall));
    tick();
    check("lu_fwd_sel",     32'(fwdSel),   sels(2, 2));
    nop(); tick();
    expFwd = 4;
    check("lu_fwdcnt",      32'(fwdCnt),   32'(expFwd));
    drain();

    // addi r0 ; add r9,r0,r0 and lw r0 ; add r9,r0,r0
    issue(1, 1, 0, 0, 1, 0); tick();
    issue(1, 1, 0, 9, 0, 0);
    check("r0_alu_stall", 32'(stall), 0);
    tick();
    check("r0_alu_sel",   32'(fwdSel), 0);
    issue(1, 1, 1, 0, 1, 0); tick();
    issue(1, 1, 0, 9, 0, 0);
    check("r0_load_stall", 32'(stall), 0);
    tick();
    drain();

    // Flush coinciding with a load-use condition
    issue(1, 1, 1, 7, 1, 0); tick();
    flush = 1'b1;
    issue(1, 1, 0, 8, 7, 7);
    check("flush_beats_stall", 32'(stall), 0);
    tick();
    flush = 1'b0;
    nop();
    check("flush_stallcnt", 32'(stallCnt), 32'(expStall));
    check("flush_bubble_sel", 32'(fwdSel), 0);
    drain();

    // Freeze held over a forwarding EX cycle
    issue(1, 1, 0, 3, 1, 2); tick();
    issue(1, 1, 0, 4, 3, 3); tick();
    check("frz_pre_sel", 32'(fwdSel), sels(1, 1));
    freeze = 1'b1;
    nop();
    for (int c = 0; c < 10; c++) begin
      tick();
      check("frz_sel", 32'(fwdSel), sels(1, 1));
      check("frz_fwdcnt", 32'(fwdCnt), 32'(expFwd));
    end
    freeze = 1'b0;
    #1;
    check("frz_release_sel", 32'(fwdSel), sels(1, 1));
    tick();
    expFwd = 5;
    check("frz_release_cnt", 32'(fwdCnt), 32'(expFwd));
    drain();

    // 20 load-use stalls; 4-bit instance saturates
    for (int n = 0; n < 20; n++) begin
      issue(1, 1, 1, 7, 1, 0); tick();
      issue(1, 1, 0, 8, 7, 7); tick();
      tick();
    end
    nop(); tick();
    expStall = 21;
    expFwd   = 25;
    check("sat_stallcnt",  32'(stallCnt),  32'(expStall));
    check("sat_fwdcnt",    32'(fwdCnt),    32'(expFwd));
    check("sat_stallcnt4", 32'(stallCnt4), 15);
    check("sat_fwdcnt4",   32'(fwdCnt4),   15);
    drain();

    // Reset while a stall is asserted
    issue(1, 1, 1, 7, 1, 0); tick();
    issue(1, 1, 0, 8, 7, 7);
    check("rst_pre_stall", 32'(stall), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_stall",     32'(stall),     0);
    check("rst_sel",       32'(fwdSel),    0);
    check("rst_stallcnt",  32'(stallCnt),  0);
    check("rst_fwdcnt",    32'(fwdCnt),    0);
    check("rst_stallcnt4", 32'(stallCnt4), 0);
    check("rst_stall4",    32'(stall4),    0);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the pipelined CPU. It replaces the fixed two-source, two-stage forwarding logic with an internal scoreboard that tracks in-flight destination registers over DEPTH post-ID slots. It produces per-operand forward selects for the EX stage and load-use stalls for ID, and keeps stall and forward statistics. It honours the L1 cache freeze and branch flush.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width
- NUM_SRC, 2, source operands per instruction
- DEPTH, 3, tracked slots (0=EX, 1=MEM, 2=WB, ...); minimum 2
- LOAD_SLOT, 2, first slot at which load data is forwardable; range 1..DEPTH-1
- SEL_W, $clog2(DEPTH), forward select width
- CNT_W, 16, statistics counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- freeze_i  in  1  cache miss stall; whole pipeline holds
- flush_i  in  1  ID instruction discarded (taken branch)
- id_valid_i  in  1  ID holds a real instruction
- id_regwrite_i  in  1  ID instruction writes rd
- id_memread_i  in  1  ID instruction is a load
- id_rd_i  in  REG_ADDR_W  ID destination
- id_rs_i  in  NUM_SRC*REG_ADDR_W  ID sources; operand i at bits [i*REG_ADDR_W +: REG_ADDR_W]
- stall_o  out  1  load-use stall: hold PC and IF/ID, bubble into EX
- fwd_sel_o  out  NUM_SRC*SEL_W  per EX operand: 0 = register file, k = forward from slot k
- stall_cnt_o  out  CNT_W  saturating count of stall_o cycles
- fwd_cnt_o  out  CNT_W  saturating count of cycles with any nonzero fwd_sel

## Operation
- Slot entry: valid, regwrite, memread, rd. Slot 0 also holds the EX instruction's sources (ex_rs).
- Live producer: valid && regwrite && rd != 0. rd = 0 never matches.
- Forwarding: for EX operand i, fwd_sel = the smallest k in 1..DEPTH-1 with live slot k and slot[k].rd == ex_rs[i]. Nearest wins. If none matches, the select is 0. A load in slot k < LOAD_SLOT never matches; the stall guarantees this case cannot occur.
- Load-use stall: stall_o = id_valid_i && !flush_i && some ID source equals a live slot j with memread and j < LOAD_SLOT-1.
- Update each clock edge, priority rst > freeze > normal:
  - rst_i: all slots invalid, counters 0.
  - freeze_i: all slots and counters hold. stall_o is still computed. Counters do not count while frozen.
  - normal: slot[k] <= slot[k-1] for k >= 1.
  - Slot 0 loads the ID instruction (its fields and ex_rs <= id_rs_i) unless flush_i or stall_o; in that case slot 0 loads a bubble (valid = 0).
- Counters saturate at all-ones and never wrap.
- Outputs when idle or after reset: stall_o = 0, fwd_sel_o = 0, counters = 0.

## Timing
- fwd_sel_o is a combinational function of slot registers only, with no input-to-output path. It is valid throughout the EX cycle.
- stall_o is combinational from the id_* inputs and slot registers. It is valid in the same cycle.
- For LOAD_SLOT = 2, a load-use stall lasts exactly 1 cycle. In general it lasts LOAD_SLOT-1-j cycles, re-evaluated each cycle.
- Back-to-back dependency with distance d (1 <= d <= DEPTH-1): the consumer sees fwd_sel = d in its EX cycle.
- Simultaneous flush_i and stall condition: flush wins and stall_o = 0.
- Reset mid-stall: stall_o drops the cycle after rst_i is sampled, because the slots are empty.

## Structure
- Package fwd_pkg holds REG_ADDR_W, the slot record typedef (valid, regwrite, memread, rd), and the select encoding constant FWD_RF = 0.
- One sub-module, fwd_match: a per-operand nearest-slot priority comparator. It is instantiated NUM_SRC times for forwarding, and reused with a slot mask of < LOAD_SLOT-1 for stall detection.

## Test plan
- Dependent ALU pair: add r3 then sub r4,r3,r1 -> fwd_sel[0] = 1 in sub's EX cycle; fwd_cnt_o increments by 1.
- Distance 2 with rt operand: add r5; nop; or r6,r2,r5 -> fwd_sel[1] = 2. The case with both slots writing r5 -> fwd_sel[1] = 1 (nearest).
- Load-use: lw r7 followed by add r8,r7,r7 -> stall_o = 1 for exactly 1 cycle and slot 0 gets a bubble. Then fwd_sel = {2,2}; stall_cnt_o = 1.
- Register zero: addi r0,...; add r9,r0,r0 -> fwd_sel = 0, no stall.
- Freeze during a forward: freeze_i held 10 cycles -> fwd_sel_o, slots and counters stable. After release, the pipeline resumes with identical selects.
- Reset and saturation: rst_i mid-stall -> next cycle all outputs are 0. With CNT_W = 4 and 20 stalls, stall_cnt_o = 15.
